// File: rtl/buyruk_getir_denetci.sv
// Instruction-fetch sequencer: loads a program into a local buffer over a
// valid/ready port, holds the core in reset until started, then serves
// instructions combinationally from the core's byte program counter.
// Optional macro ISLEMCI_IZ_EN adds a registered trace port of served
// instructions (iz_gecerli, iz_ps, iz_buyruk).
module buyruk_getir_denetci #(
   parameter int unsigned DERINLIK    = 32,
   parameter int unsigned ADRES_W     = 5,
   parameter int unsigned MAKS_CEVRIM = 1024,
   parameter logic [31:0] BOS_BUYRUK  = 32'h0000_0013
) (
   input  logic               saat,
   input  logic               reset,
   input  logic               yukle_gecerli,
   input  logic [31:0]        yukle_veri,
   input  logic               yukle_son,
   output logic               yukle_hazir,
   input  logic               basla,
   input  logic               dur,
   input  logic [31:0]        ps,
   output logic [31:0]        buyruk,
   output logic               islemci_reset,
   output logic [2:0]         durum,
   output logic [ADRES_W:0]   program_uzun,
   output logic [31:0]        cevrim_sayac,
   output logic [1:0]         hata_kodu
`ifdef ISLEMCI_IZ_EN
   ,
   output logic               iz_gecerli,
   output logic [31:0]        iz_ps,
   output logic [31:0]        iz_buyruk
`endif
);

   typedef enum logic [2:0] {
      BOS   = 3'd0,
      YUKLE = 3'd1,
      HAZIR = 3'd2,
      CALIS = 3'd3,
      BITTI = 3'd4
   } durum_e;

   localparam logic [1:0] HATA_YOK     = 2'd0;
   localparam logic [1:0] HATA_HIZA    = 2'd1;
   localparam logic [1:0] HATA_ZAMAN   = 2'd2;

   durum_e             durum_q, durum_d;
   logic [ADRES_W-1:0] yaz_ptr_q, yaz_ptr_d;
   logic [ADRES_W:0]   program_uzun_q, program_uzun_d;
   logic [31:0]        cevrim_sayac_q, cevrim_sayac_d;
   logic [1:0]         hata_kodu_q, hata_kodu_d;
   logic [31:0]        mem_q [DERINLIK];

   logic               kabul_c;
   logic               yaz_en_c;
   logic [ADRES_W-1:0] yaz_adr_c;
   logic               hizmet_c;
   logic [ADRES_W-1:0] idx_c;
   logic [31:0]        sinir_c;

   // Outputs decoded directly from registered state
   assign yukle_hazir   = (durum_q != CALIS);
   assign islemci_reset = (durum_q != CALIS);
   assign durum         = durum_q;
   assign program_uzun  = program_uzun_q;
   assign cevrim_sayac  = cevrim_sayac_q;
   assign hata_kodu     = hata_kodu_q;

   assign kabul_c = yukle_gecerli && (durum_q != CALIS);
   assign idx_c   = ps[ADRES_W+1:2];
   assign sinir_c = 32'(program_uzun_q) << 2;

   // Next-state, buffer write control and served instruction
   always_comb begin
      durum_d        = durum_q;
      yaz_ptr_d      = yaz_ptr_q;
      program_uzun_d = program_uzun_q;
      cevrim_sayac_d = cevrim_sayac_q;
      hata_kodu_d    = hata_kodu_q;
      yaz_en_c       = 1'b0;
      yaz_adr_c      = yaz_ptr_q;
      hizmet_c       = 1'b0;
      buyruk         = BOS_BUYRUK;

      unique case (durum_q)
         BOS: begin
            if (kabul_c) begin
               yaz_en_c  = 1'b1;
               yaz_adr_c = '0;
               yaz_ptr_d = ADRES_W'(1);
               durum_d   = YUKLE;
            end
         end
         YUKLE: begin
            if (kabul_c) begin
               yaz_en_c  = 1'b1;
               yaz_ptr_d = yaz_ptr_q + ADRES_W'(1);
               if (yukle_son || (yaz_ptr_q == ADRES_W'(DERINLIK - 1))) begin
                  program_uzun_d = (ADRES_W+1)'(yaz_ptr_q) + (ADRES_W+1)'(1);
                  durum_d        = HAZIR;
               end
            end
         end
         HAZIR, BITTI: begin
            // A new load has priority over a start request
            if (kabul_c) begin
               yaz_en_c  = 1'b1;
               yaz_adr_c = '0;
               yaz_ptr_d = ADRES_W'(1);
               durum_d   = YUKLE;
            end else if (basla) begin
               cevrim_sayac_d = '0;
               hata_kodu_d    = HATA_YOK;
               durum_d        = CALIS;
            end
         end
         CALIS: begin
            if (dur) begin
               durum_d = BITTI;
            end else if (ps[1:0] != 2'b00) begin
               hata_kodu_d = HATA_HIZA;
               durum_d     = BITTI;
            end else if (ps >= sinir_c) begin
               hata_kodu_d = HATA_YOK;
               durum_d     = BITTI;
            end else if (cevrim_sayac_q == 32'(MAKS_CEVRIM)) begin
               hata_kodu_d = HATA_ZAMAN;
               durum_d     = BITTI;
            end else begin
               hizmet_c = 1'b1;
               buyruk   = mem_q[idx_c];
               if (cevrim_sayac_q != '1) begin
                  cevrim_sayac_d = cevrim_sayac_q + 32'd1;
               end
            end
         end
         default: durum_d = BOS;
      endcase
   end

   // Control state registers
   always_ff @(posedge saat or posedge reset) begin
      if (reset) begin
         durum_q        <= BOS;
         yaz_ptr_q      <= '0;
         program_uzun_q <= '0;
         cevrim_sayac_q <= '0;
         hata_kodu_q    <= HATA_YOK;
      end else begin
         durum_q        <= durum_d;
         yaz_ptr_q      <= yaz_ptr_d;
         program_uzun_q <= program_uzun_d;
         cevrim_sayac_q <= cevrim_sayac_d;
         hata_kodu_q    <= hata_kodu_d;
      end
   end

   // Program buffer; contents are not reset
   always_ff @(posedge saat) begin
      if (yaz_en_c) begin
         mem_q[yaz_adr_c] <= yukle_veri;
      end
   end

`ifdef ISLEMCI_IZ_EN
   // Trace of each served instruction, one cycle later
   always_ff @(posedge saat or posedge reset) begin
      if (reset) begin
         iz_gecerli <= 1'b0;
         iz_ps      <= '0;
         iz_buyruk  <= '0;
      end else begin
         iz_gecerli <= hizmet_c;
         if (hizmet_c) begin
            iz_ps     <= ps;
            iz_buyruk <= buyruk;
         end
      end
   end
`endif

endmodule

// File: tb/tb_buyruk_getir_denetci.sv
// Directed bench for buyruk_getir_denetci (MAKS_CEVRIM reduced to 16).
module tb_buyruk_getir_denetci;

   localparam int unsigned DERINLIK = 32;
   localparam int unsigned ADRES_W  = 5;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic              saat = 1'b0;
   logic              reset;
   logic              yukle_gecerli;
   logic [31:0]       yukle_veri;
   logic              yukle_son;
   logic              yukle_hazir;
   logic              basla;
   logic              dur;
   logic [31:0]       ps;
   logic [31:0]       buyruk;
   logic              islemci_reset;
   logic [2:0]        durum;
   logic [ADRES_W:0]  program_uzun;
   logic [31:0]       cevrim_sayac;
   logic [1:0]        hata_kodu;
`ifdef ISLEMCI_IZ_EN
   logic              iz_gecerli;
   logic [31:0]       iz_ps;
   logic [31:0]       iz_buyruk;
`endif

   int passed = 0;
   int failed = 0;
   int total  = 0;

   buyruk_getir_denetci #(
      .DERINLIK   (DERINLIK),
      .ADRES_W    (ADRES_W),
      .MAKS_CEVRIM(16),
      .BOS_BUYRUK (NOP)
   ) dut (
      .saat          (saat),
      .reset         (reset),
      .yukle_gecerli (yukle_gecerli),
      .yukle_veri    (yukle_veri),
      .yukle_son     (yukle_son),
      .yukle_hazir   (yukle_hazir),
      .basla         (basla),
      .dur           (dur),
      .ps            (ps),
      .buyruk        (buyruk),
      .islemci_reset (islemci_reset),
      .durum         (durum),
      .program_uzun  (program_uzun),
      .cevrim_sayac  (cevrim_sayac),
      .hata_kodu     (hata_kodu)
`ifdef ISLEMCI_IZ_EN
      ,
      .iz_gecerli    (iz_gecerli),
      .iz_ps         (iz_ps),
      .iz_buyruk     (iz_buyruk)
`endif
   );

   always #5 saat = ~saat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge saat);
      #1;
   endtask

   task automatic yukle(input logic [31:0] w, input logic son);
      yukle_gecerli = 1'b1;
      yukle_veri    = w;
      yukle_son     = son;
      tick();
      yukle_gecerli = 1'b0;
      yukle_son     = 1'b0;
   endtask

   task automatic baslat();
      basla = 1'b1;
      tick();
      basla = 1'b0;
   endtask

   initial begin
      reset = 1'b1; yukle_gecerli = 1'b0; yukle_veri = '0; yukle_son = 1'b0;
      basla = 1'b0; dur = 1'b0; ps = '0;
      repeat (2) @(posedge saat);
      #1;
      chk("rst_durum", 32'(durum), 32'd0);
      chk("rst_hazir", 32'(yukle_hazir), 32'd1);
      chk("rst_ireset", 32'(islemci_reset), 32'd1);
      chk("rst_buyruk", buyruk, NOP);
      chk("rst_uzun", 32'(program_uzun), 32'd0);
      chk("rst_sayac", cevrim_sayac, 32'd0);
      chk("rst_hata", 32'(hata_kodu), 32'd0);
      reset = 1'b0;

      // basla ignored in BOS
      baslat();
      chk("bos_basla_yok", 32'(durum), 32'd0);

      // Three-word program
      yukle(32'h0070_0313, 1'b0);
      chk("yukle_durum", 32'(durum), 32'd1);
      baslat();
      chk("yukle_basla_yok", 32'(durum), 32'd1);
      yukle(32'h0053_0113, 1'b0);
      yukle(32'h0011_00B3, 1'b1);
      chk("hazir_durum", 32'(durum), 32'd2);
      chk("hazir_uzun", 32'(program_uzun), 32'd3);
      chk("hazir_ireset", 32'(islemci_reset), 32'd1);
      baslat();
      chk("calis_durum", 32'(durum), 32'd3);
      chk("calis_ireset", 32'(islemci_reset), 32'd0);
      chk("calis_hazir", 32'(yukle_hazir), 32'd0);
      ps = 32'd0; #1;
      chk("ps0", buyruk, 32'h0070_0313);
      tick();
      ps = 32'd4; #1;
      chk("ps4", buyruk, 32'h0053_0113);
      tick();
      ps = 32'd8; #1;
      chk("ps8", buyruk, 32'h0011_00B3);
      tick();
      ps = 32'd12; #1;
      chk("ps12_nop", buyruk, NOP);
      chk("ps12_sayac", cevrim_sayac, 32'd3);
      tick();
      chk("son_durum", 32'(durum), 32'd4);
      chk("son_sayac", cevrim_sayac, 32'd3);
      chk("son_hata", 32'(hata_kodu), 32'd0);
      chk("son_ireset", 32'(islemci_reset), 32'd1);

      // Misaligned ps
      ps = 32'd0;
      baslat();
      chk("hiza_calis", 32'(durum), 32'd3);
      chk("hiza_sayac0", cevrim_sayac, 32'd0);
      tick();
      ps = 32'd2; #1;
      chk("hiza_nop", buyruk, NOP);
      tick();
      chk("hiza_durum", 32'(durum), 32'd4);
      chk("hiza_hata", 32'(hata_kodu), 32'd1);
      chk("hiza_sayac", cevrim_sayac, 32'd1);

      // Restart clears error; dur aborts with no error
      ps = 32'd0;
      baslat();
      chk("dur_hata_temiz", 32'(hata_kodu), 32'd0);
      dur = 1'b1; #1;
      chk("dur_nop", buyruk, NOP);
      tick();
      dur = 1'b0;
      chk("dur_durum", 32'(durum), 32'd4);
      chk("dur_hata", 32'(hata_kodu), 32'd0);
      chk("dur_sayac", cevrim_sayac, 32'd0);

      // ps far beyond the buffer must not alias to mem[0]
      baslat();
      ps = 32'h0000_0080; #1;
      chk("alias_nop", buyruk, NOP);
      tick();
      chk("alias_durum", 32'(durum), 32'd4);
      chk("alias_hata", 32'(hata_kodu), 32'd0);

      // Timeout: jal x0,0 loop at ps=0
      ps = 32'd0;
      yukle(32'h0000_006F, 1'b0);
      yukle(32'h0000_006F, 1'b1);
      chk("zaman_hazir", 32'(durum), 32'd2);
      baslat();
      chk("zaman_ilk", buyruk, 32'h0000_006F);
      repeat (16) tick();
      chk("zaman_sayac", cevrim_sayac, 32'd16);
      chk("zaman_calis", 32'(durum), 32'd3);
      chk("zaman_nop", buyruk, NOP);
      tick();
      chk("zaman_durum", 32'(durum), 32'd4);
      chk("zaman_hata", 32'(hata_kodu), 32'd2);
      chk("zaman_sayac_tut", cevrim_sayac, 32'd16);

      // Full buffer without yukle_son
      for (int i = 0; i < 32; i++) begin
         yukle(32'h0000_0100 + 32'(i), 1'b0);
         if (i == 30) chk("dolu_oncesi", 32'(durum), 32'd1);
      end
      chk("dolu_durum", 32'(durum), 32'd2);
      chk("dolu_uzun", 32'(program_uzun), 32'd32);
      baslat();
      ps = 32'd124; #1;
      chk("dolu_son_kelime", buyruk, 32'h0000_011F);
      tick();
      ps = 32'd128; #1;
      chk("dolu_sinir_nop", buyruk, NOP);
      tick();
      chk("dolu_bitti", 32'(durum), 32'd4);
      chk("dolu_sayac", cevrim_sayac, 32'd1);
      yukle(32'h0000_0AAA, 1'b0);
      chk("yeni_yukle", 32'(durum), 32'd1);
      chk("yeni_uzun_eski", 32'(program_uzun), 32'd32);
      yukle(32'h0000_0BBB, 1'b1);
      chk("yeni_hazir", 32'(durum), 32'd2);
      chk("yeni_uzun", 32'(program_uzun), 32'd2);

      // Load wins over basla in HAZIR
      basla = 1'b1;
      yukle(32'h0000_00AA, 1'b0);
      basla = 1'b0;
      chk("yaris_durum", 32'(durum), 32'd1);
      chk("yaris_uzun", 32'(program_uzun), 32'd2);
      yukle(32'h0000_00BB, 1'b0);
      yukle(32'h0000_00CC, 1'b1);
      chk("yaris_hazir", 32'(durum), 32'd2);
      chk("yaris_uzun_yeni", 32'(program_uzun), 32'd3);
      ps = 32'd0;
      baslat();
      chk("yaris_ps0", buyruk, 32'h0000_00AA);
      tick();
      ps = 32'd8; #1;
      chk("yaris_ps8", buyruk, 32'h0000_00CC);

      // Asynchronous reset mid-run
      reset = 1'b1; #1;
      chk("arst_durum", 32'(durum), 32'd0);
      chk("arst_ireset", 32'(islemci_reset), 32'd1);
      chk("arst_hazir", 32'(yukle_hazir), 32'd1);
      chk("arst_sayac", cevrim_sayac, 32'd0);
      chk("arst_uzun", 32'(program_uzun), 32'd0);
      chk("arst_buyruk", buyruk, NOP);
      tick();
      reset = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
